exception_sequencer: RTL
========================

EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 The block SHALL have parameter VEC_OPCODE, default 8'd253, the memory byte address holding the invalid-opcode handler address.
REQ-002 The block SHALL have parameter VEC_OVERFLOW, default 8'd254, the memory byte address holding the overflow handler address.
REQ-003 The block SHALL have parameter VEC_DIVZERO, default 8'd255, the memory byte address holding the divide-by-zero handler address.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; the ports are `clk` and `reset`.
REQ-005 The ports SHALL be, in order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- invalid_opcode  in  1  decode found an unknown opcode/funct
- Overflow  in  1  ALU overflow on a trapping instruction
- divzero  in  1  divider saw a zero divisor
- pc_in  in  32  current PC value (already incremented by fetch)
- mem_data_in  in  32  memory read data
- busy  out  1  sequence in progress; the control unit holds all other writes
- mem_addr  out  32  memory read address
- epc_write  out  1  EPC load enable
- epc_data  out  32  value to load into EPC
- pc_write  out  1  PC load enable
- pc_data  out  32  handler address to load into PC
- cause  out  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 divzero
- done  out  1  one-cycle pulse when the handler PC is written

Function
REQ-006 The FSM SHALL have the states IDLE, SAVE, WAIT and LOAD, with transitions IDLE->SAVE on a trigger, then SAVE->WAIT->LOAD->IDLE unconditionally.
REQ-007 In IDLE, any asserted exception input at a rising edge SHALL be a trigger; the block SHALL latch cause and pc_in on that edge.
REQ-008 When exception inputs assert simultaneously, priority SHALL be invalid_opcode > Overflow > divzero; lower-priority inputs are dropped.
REQ-009 Exception inputs asserted while not in IDLE SHALL be ignored and not queued.
REQ-010 In SAVE, epc_write SHALL be 1 for exactly one cycle, with epc_data = latched pc_in - 4 modulo 2^32 (pc_in=0 gives 0xFFFFFFFC).
REQ-011 From SAVE through LOAD, mem_addr SHALL equal the zero-extended vector for the latched cause; in IDLE, mem_addr SHALL be 0.
REQ-012 Memory read data SHALL be valid two cycles after the address is presented; the block SHALL sample mem_data_in only in LOAD.
REQ-013 In LOAD, pc_write SHALL be 1 and done SHALL be 1 for one cycle, with pc_data = {24'b0, mem_data_in[7:0]}.
REQ-014 Latency SHALL be fixed: trigger edge N gives SAVE in cycle N+1, pc_write in N+3, and IDLE again in N+4.
REQ-015 busy SHALL be 1 exactly in SAVE, WAIT and LOAD.
REQ-016 cause SHALL hold its latched value until the next trigger; it is not cleared on return to IDLE.
REQ-017 epc_data and pc_data SHALL be 0 whenever their enables are 0.

Reset
REQ-018 While reset is 1 at a rising edge, the block SHALL go to IDLE, and every output (busy, mem_addr, epc_write, epc_data, pc_write, pc_data, cause, done) SHALL be 0.
REQ-019 A reset asserted in any non-IDLE state SHALL abort the sequence, and no pc_write or epc_write SHALL occur on or after that edge.
REQ-020 Exception inputs SHALL be ignored in the cycle that reset is asserted.

Structure
REQ-021 The cause encodings, the three vector defaults and the state encodings SHALL live in the shared CPU package used by control_unit.
REQ-022 The block SHALL be a single module with no sub-modules; the vector mux and the PC-4 subtractor are inline.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Overflow=1 for one cycle, pc_in=0x00000040, memory byte at 254 = 0x7C -> epc_write with epc_data=0x0000003C at N+1; pc_write with pc_data=0x0000007C and done at N+3; cause=10.
- invalid_opcode=1, Overflow=1 and divzero=1 together -> mem_addr=253 and cause=01; only one sequence runs.
- divzero=1 with pc_in=0x00000000 -> epc_data=0xFFFFFFFC, mem_addr=255, cause=11.
- Overflow=1 in IDLE, then divzero=1 in WAIT -> a single sequence with cause=10, busy low at N+4, and no second trigger.
- Trigger, then reset=1 in WAIT -> no pc_write, and all outputs 0 on the next cycle.
- Back-to-back: a new trigger in the first IDLE cycle after done -> the full sequence repeats with the same N+1/N+3 timing.

Source files
------------

// File: rtl/exception_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// exception_sequencer_pkg
// Shared CPU definitions used by control_unit and exception_sequencer:
//   - exc_cause_e : exception cause encodings (also the value on the cause port)
//   - exc_state_e : exception sequencer FSM state encodings
//   - default memory byte addresses of the three handler vectors
//   - helpers for cause prioritisation and vector selection
// -----------------------------------------------------------------------------
package exception_sequencer_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_OPCODE   = 2'b01,
        CAUSE_OVERFLOW = 2'b10,
        CAUSE_DIVZERO  = 2'b11
    } exc_cause_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SAVE = 2'b01,
        WAIT = 2'b10,
        LOAD = 2'b11
    } exc_state_e;

    localparam logic [7:0] VEC_OPCODE_DEFAULT   = 8'd253;
    localparam logic [7:0] VEC_OVERFLOW_DEFAULT = 8'd254;
    localparam logic [7:0] VEC_DIVZERO_DEFAULT  = 8'd255;

    // Fixed priority: invalid opcode beats overflow beats divide-by-zero.
    function automatic exc_cause_e prioritize_cause(
        input logic invalid_opcode,
        input logic overflow,
        input logic divzero
    );
        exc_cause_e result;
        if (invalid_opcode) begin
            result = CAUSE_OPCODE;
        end else if (overflow) begin
            result = CAUSE_OVERFLOW;
        end else if (divzero) begin
            result = CAUSE_DIVZERO;
        end else begin
            result = CAUSE_NONE;
        end
        return result;
    endfunction

    // Map a cause onto the memory byte address holding its handler address.
    function automatic logic [7:0] select_vector(
        input exc_cause_e cause,
        input logic [7:0] vec_opcode,
        input logic [7:0] vec_overflow,
        input logic [7:0] vec_divzero
    );
        logic [7:0] result;
        case (cause)
            CAUSE_OPCODE:   result = vec_opcode;
            CAUSE_OVERFLOW: result = vec_overflow;
            CAUSE_DIVZERO:  result = vec_divzero;
            default:        result = 8'd0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/exception_sequencer.sv
// -----------------------------------------------------------------------------
// exception_sequencer
// Takes an exception raised by decode/ALU/divider, saves the faulting PC
// (pc_in - 4) into EPC, fetches the handler address from a vector location
// in memory and loads it into the PC. Fixed four-cycle sequence:
// IDLE -> SAVE -> WAIT -> LOAD -> IDLE.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   invalid_opcode    decode found an unknown opcode/funct
//   Overflow          ALU overflow on a trapping instruction
//   divzero           divider saw a zero divisor
//   pc_in[31:0]       current (already incremented) PC
//   mem_data_in[31:0] memory read data, valid two cycles after mem_addr
//   busy              sequence in progress (SAVE/WAIT/LOAD)
//   mem_addr[31:0]    vector address during the sequence, 0 in IDLE
//   epc_write/epc_data EPC load strobe and value (pc_in - 4)
//   pc_write/pc_data  PC load strobe and handler address
//   cause[1:0]        latched cause, held until the next trigger
//   done              one-cycle pulse together with pc_write
// -----------------------------------------------------------------------------
module exception_sequencer
    import exception_sequencer_pkg::*;
#(
    parameter logic [7:0] VEC_OPCODE   = VEC_OPCODE_DEFAULT,
    parameter logic [7:0] VEC_OVERFLOW = VEC_OVERFLOW_DEFAULT,
    parameter logic [7:0] VEC_DIVZERO  = VEC_DIVZERO_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        invalid_opcode,
    input  logic        Overflow,
    input  logic        divzero,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        epc_write,
    output logic [31:0] epc_data,
    output logic        pc_write,
    output logic [31:0] pc_data,
    output logic [1:0]  cause,
    output logic        done
);

    exc_state_e  state_r;
    exc_state_e  state_s;
    exc_cause_e  cause_r;
    exc_cause_e  cause_s;
    exc_cause_e  trig_cause_s;
    logic        trigger_s;

    logic        busy_r;
    logic [31:0] mem_addr_r;
    logic        epc_write_r;
    logic [31:0] epc_data_r;
    logic        pc_write_r;
    logic        done_r;

    // Only the low byte of the vector word is the handler address.
    logic        unused_mem_hi_s;
    assign unused_mem_hi_s = ^mem_data_in[31:8];

    // Next-state logic; a trigger is only recognised in IDLE so exceptions
    // raised mid-sequence are dropped rather than queued.
    always_comb begin
        trig_cause_s = prioritize_cause(invalid_opcode, Overflow, divzero);
        trigger_s    = 1'b0;
        state_s      = state_r;
        case (state_r)
            IDLE: begin
                if (trig_cause_s != CAUSE_NONE) begin
                    trigger_s = 1'b1;
                    state_s   = SAVE;
                end else begin
                    state_s   = IDLE;
                end
            end
            SAVE:    state_s = WAIT;
            WAIT:    state_s = LOAD;
            LOAD:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Cause seen by the output registers: new cause on a trigger, else held.
    always_comb begin
        if (trigger_s) begin
            cause_s = trig_cause_s;
        end else begin
            cause_s = cause_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Cause latch; survives the return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_r <= CAUSE_NONE;
        end else begin
            cause_r <= cause_s;
        end
    end

    // Output registers decoded from the next state so every strobe lines up
    // with the state it belongs to. SAVE is only entered on a trigger edge,
    // so pc_in sampled here is the latched PC for the EPC write.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r      <= 1'b0;
            mem_addr_r  <= 32'd0;
            epc_write_r <= 1'b0;
            epc_data_r  <= 32'd0;
            pc_write_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r      <= (state_s != IDLE);
            mem_addr_r  <= (state_s != IDLE)
                           ? {24'd0, select_vector(cause_s, VEC_OPCODE, VEC_OVERFLOW, VEC_DIVZERO)}
                           : 32'd0;
            epc_write_r <= (state_s == SAVE);
            epc_data_r  <= (state_s == SAVE) ? (pc_in - 32'd4) : 32'd0;
            pc_write_r  <= (state_s == LOAD);
            done_r      <= (state_s == LOAD);
        end
    end

    assign busy      = busy_r;
    assign mem_addr  = mem_addr_r;
    assign epc_write = epc_write_r;
    assign epc_data  = epc_data_r;
    assign pc_write  = pc_write_r;
    // Read data arrives in LOAD itself, so it is forwarded rather than
    // registered; gated to zero outside the write strobe.
    assign pc_data   = pc_write_r ? {24'd0, mem_data_in[7:0]} : 32'd0;
    assign cause     = cause_r;
    assign done      = done_r;

endmodule
